jt12_mux_dac: RTL and testbench

Demultiplexer and reconstruction stage on the receive side of the JT12 per-channel multiplexed DAC stream. Consumes the time-multiplexed 9-bit left/right channel samples, one channel every four `clk_en` periods; six channels form one frame. It stores the latest value of each channel, sums each complete frame into 12-bit stereo, and raises a sample strobe. It sits between the FM accumulator's multiplexed outputs and the board-level audio path, and also gives per-channel readback for debug and visualisation.

---
 rtl/jt12_mux_dac_if.sv | 11 +
 rtl/jt12_mux_dac.sv | 137 +++++++++++++
 tb/tb_jt12_mux_dac.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/jt12_mux_dac_if.sv
// Multiplexed DAC sample stream from the FM accumulator: one channel per strobe, six channels per frame.
// No handshake back to the source. The receiver must keep up with every strobe.
interface jt12_mux_dac_if;
    logic signed [8:0] mux_left;
    logic signed [8:0] mux_right;
    logic              mux_sample;
    logic              ch_sync;

    modport master (output mux_left, mux_right, mux_sample, ch_sync);
    modport slave  (input  mux_left, mux_right, mux_sample, ch_sync);
endinterface

// File: rtl/jt12_mux_dac.sv
// Purpose: demux six time-multiplexed 9-bit stereo channels, sum each frame to 12-bit and give per-channel readback.
// Latency: left/right/sample are valid one clk after the channel-5 strobe; readback is one clk behind ch_sel or a slot write.
// Backpressure: none. Strobes are always accepted. JT12_MUX_DAC_GAIN_EN selects the x2 saturating output stage.
module jt12_mux_dac #(
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    jt12_mux_dac_if.slave      bus,
    input  logic [2:0]         ch_sel,
    output logic signed [11:0] left,
    output logic signed [11:0] right,
    output logic               sample,
    output logic signed [8:0]  ch_left,
    output logic signed [8:0]  ch_right,
    output logic               locked,
    output logic               resync
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {UNSYNC, RUN} state_t;

    state_t                  state;
    logic [2:0]              cnt;
    logic [TW-1:0]           to_cnt;
    logic signed [11:0]      accl, accr;
    logic signed [8:0]       slot_l [8];
    logic signed [8:0]       slot_r [8];
    logic signed [11:0]      inl, inr, suml, sumr;

    function automatic logic signed [11:0] ext(input logic signed [8:0] v);
        return {{3{v[8]}}, v};
    endfunction

    function automatic logic signed [11:0] scale(input logic signed [11:0] s);
`ifdef JT12_MUX_DAC_GAIN_EN
        if (s > 12'sd1023)
            return 12'sd2047;
        else if (s < -12'sd1024)
            return 12'sh800;
        else
            return s <<< 1;
`else
        return s;
`endif
    endfunction

    assign inl  = ext(bus.mux_left);
    assign inr  = ext(bus.mux_right);
    assign suml = accl + inl;
    assign sumr = accr + inr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= UNSYNC;
            cnt      <= '0;
            to_cnt   <= '0;
            accl     <= '0;
            accr     <= '0;
            left     <= '0;
            right    <= '0;
            sample   <= 1'b0;
            resync   <= 1'b0;
            locked   <= 1'b0;
            ch_left  <= '0;
            ch_right <= '0;
            for (int i = 0; i < 8; i++) begin
                slot_l[i] <= '0;
                slot_r[i] <= '0;
            end
        end else begin
            // Slots 6 and 7 are never written, but gate anyway so readback of them is zero by construction
            ch_left  <= (ch_sel < 3'd6) ? slot_l[ch_sel] : 9'sd0;
            ch_right <= (ch_sel < 3'd6) ? slot_r[ch_sel] : 9'sd0;

            if (clk_en) begin
                sample <= 1'b0;
                resync <= 1'b0;

                if (bus.mux_sample) begin
                    to_cnt <= '0;
                    case (state)
                        UNSYNC: begin
                            if (bus.ch_sync) begin
                                slot_l[0] <= bus.mux_left;
                                slot_r[0] <= bus.mux_right;
                                accl      <= inl;
                                accr      <= inr;
                                cnt       <= 3'd1;
                                state     <= RUN;
                                locked    <= 1'b1;
                            end
                        end
                        RUN: begin
                            if (bus.ch_sync || cnt == 3'd0) begin
                                // Sync mid-frame: drop the partial sums and restart on this channel 0
                                if (bus.ch_sync && cnt != 3'd0)
                                    resync <= 1'b1;
                                slot_l[0] <= bus.mux_left;
                                slot_r[0] <= bus.mux_right;
                                accl      <= inl;
                                accr      <= inr;
                                cnt       <= 3'd1;
                            end else if (cnt == 3'd5) begin
                                slot_l[5] <= bus.mux_left;
                                slot_r[5] <= bus.mux_right;
                                left      <= scale(suml);
                                right     <= scale(sumr);
                                sample    <= 1'b1;
                                accl      <= '0;
                                accr      <= '0;
                                cnt       <= 3'd0;
                            end else begin
                                slot_l[cnt] <= bus.mux_left;
                                slot_r[cnt] <= bus.mux_right;
                                accl        <= suml;
                                accr        <= sumr;
                                cnt         <= cnt + 3'd1;
                            end
                        end
                        default: state <= UNSYNC;
                    endcase
                end else if (to_cnt != TW'(TIMEOUT)) begin
                    to_cnt <= to_cnt + 1'b1;
                    if (to_cnt == TW'(TIMEOUT - 1) && state == RUN) begin
                        state  <= UNSYNC;
                        locked <= 1'b0;
                        cnt    <= '0;
                        accl   <= '0;
                        accr   <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_jt12_mux_dac.sv
// Scoreboard bench: expected frame sums are queued as frames are driven and compared when sample rises.
module tb_jt12_mux_dac;
    logic               clk = 1'b0;
    logic               rst;
    logic               clk_en;
    logic [2:0]         ch_sel;
    logic signed [11:0] left, right;
    logic               sample;
    logic signed [8:0]  ch_left, ch_right;
    logic               locked, resync;

    jt12_mux_dac_if bus ();

    jt12_mux_dac #(.TIMEOUT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .bus      (bus.slave),
        .ch_sel   (ch_sel),
        .left     (left),
        .right    (right),
        .sample   (sample),
        .ch_left  (ch_left),
        .ch_right (ch_right),
        .locked   (locked),
        .resync   (resync)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int expl_q[$];
    int expr_q[$];
    int fl[6];
    int fr[6];
    int last_l, last_r;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int scale(input int s);
`ifdef JT12_MUX_DAC_GAIN_EN
        int v;
        v = s * 2;
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
        return v;
`else
        return s;
`endif
    endfunction

    task automatic tick(input bit en, input bit ms, input int l, input int r, input bit sync);
        @(negedge clk);
        clk_en         = en;
        bus.mux_sample = ms;
        bus.mux_left   = 9'(l);
        bus.mux_right  = 9'(r);
        bus.ch_sync    = sync;
        @(posedge clk);
        #1;
        if (en && sample) begin
            chk("sample_expected", int'(expl_q.size() > 0), 1);
            if (expl_q.size() > 0) begin
                chk("frame_left", left, expl_q.pop_front());
                chk("frame_right", right, expr_q.pop_front());
            end
        end
    endtask

    task automatic strobe(input int l, input int r, input bit sync);
        repeat ($urandom_range(0, 2)) tick(1'b0, 1'b1, 0, 0, 1'b0);
        tick(1'b1, 1'b1, l, r, sync);
    endtask

    task automatic send_frame();
        int sl, sr;
        sl = 0;
        sr = 0;
        for (int i = 0; i < 6; i++) begin
            sl += fl[i];
            sr += fr[i];
        end
        last_l = scale(sl);
        last_r = scale(sr);
        expl_q.push_back(last_l);
        expr_q.push_back(last_r);
        for (int i = 0; i < 6; i++) strobe(fl[i], fr[i], i == 0);
        chk("frame_consumed", expl_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        clk_en = 1'b1;
        bus.mux_sample = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clk_en = 1'b0;
        ch_sel = 3'd0;
        bus.mux_left = '0;
        bus.mux_right = '0;
        bus.mux_sample = 1'b0;
        bus.ch_sync = 1'b0;
        do_reset();

        chk("rst_left", left, 0);
        chk("rst_right", right, 0);
        chk("rst_sample", sample, 0);
        chk("rst_locked", locked, 0);
        chk("rst_resync", resync, 0);
        chk("rst_ch_left", ch_left, 0);
        chk("rst_ch_right", ch_right, 0);

        // Unsynchronised strobes must be ignored
        for (int i = 0; i < 6; i++) strobe(3, 3, 1'b0);
        chk("nosync_locked", locked, 0);

        for (int i = 0; i < 6; i++) begin fl[i] = 10; fr[i] = -5; end
        send_frame();
        chk("frame_a_locked", locked, 1);

        for (int i = 0; i < 6; i++) begin fl[i] = 255; fr[i] = -256; end
        send_frame();

        fl = '{1, 2, 100, 3, 4, 5};
        fr = '{-1, -2, -7, -3, -4, -5};
        send_frame();
        ch_sel = 3'd2;
        tick(1'b0, 1'b0, 0, 0, 1'b0);
        chk("rb2_left", ch_left, 100);
        chk("rb2_right", ch_right, -7);
        ch_sel = 3'd7;
        tick(1'b0, 1'b0, 0, 0, 1'b0);
        chk("rb7_left", ch_left, 0);
        chk("rb7_right", ch_right, 0);
        ch_sel = 3'd5;
        tick(1'b0, 1'b0, 0, 0, 1'b0);
        chk("rb5_left", ch_left, 5);

        // Sync on the fourth strobe discards the partial frame
        strobe(50, 50, 1'b1);
        strobe(50, 50, 1'b0);
        strobe(50, 50, 1'b0);
        strobe(7, -3, 1'b1);
        chk("resync_pulse", resync, 1);
        chk("resync_no_sample", sample, 0);
        fl = '{7, 11, -20, 30, 1, 2};
        fr = '{-3, 4, 5, -6, 8, -9};
        last_l = scale(7 + 11 - 20 + 30 + 1 + 2);
        last_r = scale(-3 + 4 + 5 - 6 + 8 - 9);
        expl_q.push_back(last_l);
        expr_q.push_back(last_r);
        for (int i = 1; i < 6; i++) begin
            strobe(fl[i], fr[i], 1'b0);
            if (i == 1) chk("resync_cleared", resync, 0);
        end
        chk("resync_frame_consumed", expl_q.size(), 0);

        // Timeout: only enabled periods count
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0, 0, 0, 1'b0);
            tick(1'b0, 1'b0, 0, 0, 1'b0);
        end
        chk("timeout_7_locked", locked, 1);
        tick(1'b1, 1'b0, 0, 0, 1'b0);
        chk("timeout_8_locked", locked, 0);
        chk("timeout_hold_left", left, last_l);
        chk("timeout_hold_right", right, last_r);
        for (int i = 0; i < 6; i++) strobe(9, 9, 1'b0);
        chk("timeout_nosync_locked", locked, 0);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 6; i++) begin
                fl[i] = int'($urandom_range(0, 511)) - 256;
                fr[i] = int'($urandom_range(0, 511)) - 256;
            end
            send_frame();
        end

        // Reset mid-frame: nothing survives and no frame is produced
        strobe(40, 40, 1'b1);
        strobe(40, 40, 1'b0);
        strobe(40, 40, 1'b0);
        ch_sel = 3'd0;
        do_reset();
        chk("midrst_left", left, 0);
        chk("midrst_locked", locked, 0);
        tick(1'b0, 1'b0, 0, 0, 1'b0);
        chk("midrst_ch_left", ch_left, 0);
        for (int i = 0; i < 6; i++) strobe(40, 40, 1'b0);
        chk("midrst_nosync_locked", locked, 0);
        chk("final_queue_empty", expl_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
